// File: rtl/sram_bank_array.sv
// Banked SRAM array for one AHB2SRAM port.
// The bank count and the per-bank depth are parameters, and the bank index is
// decoded from the upper address bits. After reset a sequencer zero-fills every
// bank. The block reports readiness, read-data validity and accesses that were
// dropped because initialisation had not finished.
// Each bank models cmsdk_fpga_sram behaviour: byte-masked synchronous write,
// registered read address, and read data taken from the registered address.
module sram_bank_array #(
  parameter int NUM_BANKS = 2,
  parameter int BANK_AW   = 12,
  parameter bit INIT_ZERO = 1'b1,
  localparam int BSW      = $clog2(NUM_BANKS),
  localparam int AW       = BANK_AW + BSW
) (
  input  logic          SRAMHCLK,
  input  logic          SRAMHRESET,
  input  logic [AW-1:0] SRAMADDR,
  input  logic [3:0]    SRAMWREN,
  input  logic [31:0]   SRAMWDATA,
  input  logic          SRAMCS,
  output logic [31:0]   SRAMRDATA,
  output logic          SRAMRVALID,
  output logic          SRAMREADY,
  output logic          SRAMERR
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               state_q;
  logic [BANK_AW-1:0]   icnt_q;
  logic                 rvalid_q;
  logic [BSW-1:0]       bank_sel_q;
  logic                 err_q;

  logic [BSW-1:0]       bank_idx;
  logic                 rd_req;

  logic [NUM_BANKS-1:0]        bank_cs;
  logic [BANK_AW-1:0]          bank_addr;
  logic [3:0]                  bank_wren;
  logic [31:0]                 bank_wdata;
  logic [NUM_BANKS-1:0][31:0]  bank_rdata;

  assign bank_idx = SRAMADDR[AW-1:BANK_AW];
  assign rd_req   = SRAMCS & ~|SRAMWREN;

  // Bank port steering: the init sequencer owns every bank until RUN, then only the decoded bank is selected
  always_comb begin
    bank_cs    = '0;
    bank_addr  = SRAMADDR[BANK_AW-1:0];
    bank_wren  = SRAMWREN;
    bank_wdata = SRAMWDATA;
    if (state_q == ST_INIT) begin
      bank_addr  = icnt_q;
      bank_wren  = 4'hF;
      bank_wdata = '0;
      if (INIT_ZERO) begin
        bank_cs = '1;
      end
    end else if (SRAMCS) begin
      bank_cs[bank_idx] = 1'b1;
    end
  end

  // Control FSM: init sequencing, read-valid/bank-select tracking, dropped-access error pulse
  always_ff @(posedge SRAMHCLK or posedge SRAMHRESET) begin
    if (SRAMHRESET) begin
      state_q    <= ST_INIT;
      icnt_q     <= '0;
      rvalid_q   <= 1'b0;
      bank_sel_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          rvalid_q <= 1'b0;
          err_q    <= SRAMCS;
          if (INIT_ZERO) begin
            icnt_q <= icnt_q + BANK_AW'(1);
            if (icnt_q == '1) begin
              state_q <= ST_RUN;
            end
          end else begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          err_q    <= 1'b0;
          rvalid_q <= rd_req;
          if (rd_req) begin
            bank_sel_q <= bank_idx;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [31:0]        mem [2**BANK_AW];
    logic [BANK_AW-1:0] raddr_q;

    // Bank storage: byte-masked write and read-address capture on chip select
    always_ff @(posedge SRAMHCLK) begin
      if (bank_cs[g]) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (bank_wren[k]) begin
            mem[bank_addr][8*k +: 8] <= bank_wdata[8*k +: 8];
          end
        end
        raddr_q <= bank_addr;
      end
    end

    assign bank_rdata[g] = mem[raddr_q];
  end

  assign SRAMRDATA  = rvalid_q ? bank_rdata[bank_sel_q] : '0;
  assign SRAMRVALID = rvalid_q;
  assign SRAMREADY  = (state_q == ST_RUN);
  assign SRAMERR    = err_q;

endmodule

// File: tb/tb_sram_bank_array.sv
// Bench for sram_bank_array: scoreboard of expected read data checked by an
// independent monitor, plus direct checks of ready/error/reset timing.
module tb_sram_bank_array;

  logic        clk;
  logic        rst;
  logic [5:0]  addr;
  logic [3:0]  wren;
  logic [31:0] wdata;
  logic        cs;
  logic [31:0] rdata;
  logic        rvalid;
  logic        ready;
  logic        err;

  logic        rst_b;
  logic [3:0]  addr_b;
  logic [3:0]  wren_b;
  logic [31:0] wdata_b;
  logic        cs_b;
  logic [31:0] rdata_b;
  logic        rvalid_b;
  logic        ready_b;
  logic        err_b;

  int compared;
  int mismatched;
  logic [31:0] exp_q [$];

  sram_bank_array #(.NUM_BANKS(4), .BANK_AW(4), .INIT_ZERO(1'b1)) dut (
    .SRAMHCLK(clk), .SRAMHRESET(rst), .SRAMADDR(addr), .SRAMWREN(wren),
    .SRAMWDATA(wdata), .SRAMCS(cs), .SRAMRDATA(rdata), .SRAMRVALID(rvalid),
    .SRAMREADY(ready), .SRAMERR(err)
  );

  sram_bank_array #(.NUM_BANKS(2), .BANK_AW(3), .INIT_ZERO(1'b0)) dut_b (
    .SRAMHCLK(clk), .SRAMHRESET(rst_b), .SRAMADDR(addr_b), .SRAMWREN(wren_b),
    .SRAMWDATA(wdata_b), .SRAMCS(cs_b), .SRAMRDATA(rdata_b), .SRAMRVALID(rvalid_b),
    .SRAMREADY(ready_b), .SRAMERR(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever DUT presents read data
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_rvalid: got rvalid=1 data %h, expected no read", rdata);
        end else begin
          check("read_data", rdata, exp_q.pop_front());
        end
      end else begin
        check("rdata_idle", rdata, 32'h0);
      end
      if (ready === 1'b1) check("err_in_run", {31'h0, err}, 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [5:0] a, input logic [31:0] exp);
    cs = 1'b1; wren = 4'h0; addr = a; wdata = '0;
    exp_q.push_back(exp);
    step();
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    cs = 1'b1; wren = be; addr = a; wdata = d;
    step();
  endtask

  task automatic idle();
    cs = 1'b0; wren = 4'h0;
    step();
  endtask

  logic [5:0] waddrs [4];

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1; cs = 1'b0; wren = 4'h0; addr = '0; wdata = '0;
    rst_b = 1'b1; cs_b = 1'b0; wren_b = 4'h0; addr_b = '0; wdata_b = '0;
    waddrs[0] = 6'h00; waddrs[1] = 6'h10; waddrs[2] = 6'h20; waddrs[3] = 6'h3F;

    step(); step();
    check("reset_ready", {31'h0, ready}, 32'h0);
    check("reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);

    // Release reset; count init edges, inject an access during init cycle 3
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("init_ready_%0d", k), {31'h0, ready}, (k == 16) ? 32'h1 : 32'h0);
      check($sformatf("init_err_%0d", k), {31'h0, err}, (k == 3) ? 32'h1 : 32'h0);
      if (k == 2) begin
        cs = 1'b1; wren = 4'hF; addr = 6'h07; wdata = 32'hDEAD_BEEF;
      end else begin
        cs = 1'b0; wren = 4'h0;
      end
    end

    // Access in the same cycle ready rises is accepted; sweep all addresses
    for (int a = 0; a < 64; a++) do_read(6'(a), 32'h0);
    idle();

    // Banked write then back-to-back reads
    for (int i = 0; i < 4; i++) do_write(waddrs[i], 32'hA5A5_0000 + 32'(waddrs[i]), 4'hF);
    for (int i = 0; i < 4; i++) do_read(waddrs[i], 32'hA5A5_0000 + 32'(waddrs[i]));
    idle();

    // Byte enables, plus a same-word-offset write in another bank
    do_write(6'h05, 32'h1122_3344, 4'hF);
    do_write(6'h15, 32'h5555_AAAA, 4'hF);
    do_write(6'h05, 32'hFFFF_FFFF, 4'b0101);
    do_read(6'h05, 32'h11FF_33FF);
    do_read(6'h15, 32'h5555_AAAA);
    do_read(6'h07, 32'h0);
    // Write then immediate read of the same address
    do_write(6'h2A, 32'hCAFE_0123, 4'hF);
    do_read(6'h2A, 32'hCAFE_0123);
    idle();
    idle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    // Reset mid-init
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 1; k <= 9; k++) step();
    check("midinit_ready", {31'h0, ready}, 32'h0);
    rst = 1'b1;
    #1;
    check("midinit_rst_ready", {31'h0, ready}, 32'h0);
    check("midinit_rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("midinit_rst_rdata", rdata, 32'h0);
    check("midinit_rst_err", {31'h0, err}, 32'h0);
    step();
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("reinit_ready_%0d", k), {31'h0, ready}, (k == 16) ? 32'h1 : 32'h0);
    end
    do_read(6'h05, 32'h0);
    do_read(6'h2A, 32'h0);
    idle();
    idle();
    check("scoreboard_drained2", 32'(exp_q.size()), 32'h0);

    // INIT_ZERO=0 instance
    step();
    rst_b = 1'b0;
    #1;
    check("b_ready_before_edge", {31'h0, ready_b}, 32'h0);
    step();
    check("b_ready_one_edge", {31'h0, ready_b}, 32'h1);
    cs_b = 1'b1; wren_b = 4'h0; addr_b = 4'h3;
    step();
    check("b_rvalid", {31'h0, rvalid_b}, 32'h1);
    check("b_err", {31'h0, err_b}, 32'h0);
    cs_b = 1'b1; wren_b = 4'hF; addr_b = 4'h9; wdata_b = 32'h0BAD_F00D;
    step();
    check("b_rvalid_on_write", {31'h0, rvalid_b}, 32'h0);
    check("b_rdata_on_write", rdata_b, 32'h0);
    cs_b = 1'b1; wren_b = 4'hF; addr_b = 4'h1; wdata_b = 32'h1234_5678;
    step();
    cs_b = 1'b1; wren_b = 4'h0; addr_b = 4'h9;
    step();
    check("b_read_bank1", rdata_b, 32'h0BAD_F00D);
    cs_b = 1'b1; wren_b = 4'h0; addr_b = 4'h1;
    step();
    check("b_read_bank0", rdata_b, 32'h1234_5678);
    cs_b = 1'b0;
    step();
    check("b_rvalid_idle", {31'h0, rvalid_b}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
